// File: rtl/simon_control_gen.sv
// Purpose: Simon game controller holding the pattern memory, counters and comparators.
// Latency: outputs are combinational from registered state; the memory is read asynchronously.
// Backpressure: none; every input is a single-cycle pulse and is either consumed or ignored.
module simon_control_gen #(
    parameter int PAT_W   = 4,
    parameter int DEPTH   = 16,
    parameter int LIVES   = 3,
    parameter int TIMEOUT = 8,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int LW = $clog2(LIVES + 1),
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             restart,
    input  logic             in_valid,
    input  logic [PAT_W-1:0] in_pattern,
    output logic             out_valid,
    output logic [PAT_W-1:0] out_pattern,
    output logic [2:0]       mode_leds,
    output logic [CW-1:0]    level,
    output logic [LW-1:0]    lives_left,
    output logic             win,
    output logic             lose
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [LW-1:0] LIVES_C = LW'(LIVES);
    localparam logic [TW-1:0] TMAX    = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        S_INPUT = 3'd0,
        S_PLAY  = 3'd1,
        S_REP   = 3'd2,
        S_LOSE  = 3'd3,
        S_WIN   = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     count, index;
    logic [LW-1:0]     lives, lives_dec;
    logic [TW-1:0]     timer;
    logic              win_tog;
    logic [PAT_W-1:0]  mem [DEPTH];

    logic [AW-1:0]     rd_addr, wr_addr;
    logic [PAT_W-1:0]  rd_dat;
    logic              legal_in, last, hit, tmo, fail, dead;

    assign rd_addr   = index[AW-1:0];
    assign wr_addr   = count[AW-1:0];
    assign rd_dat    = mem[rd_addr];
    assign legal_in  = in_valid && (in_pattern != '0);
    assign last      = (index + ONE_C) == count;
    assign hit       = in_pattern == rd_dat;
    // The timer expiring on this step counts as a wrong answer; a same-cycle input overrides it.
    assign tmo       = (TIMEOUT > 0) && (state == S_REP) && step && !in_valid && (timer == TMAX);
    assign fail      = ((state == S_REP) && in_valid && !hit) || tmo;
    assign lives_dec = (lives == '0) ? '0 : lives - LW'(1);
    assign dead      = lives_dec == '0;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_INPUT;
        else        state <= state_nxt;
    end

    // Next-state decision.
    always_comb begin
        state_nxt = state;
        case (state)
            S_INPUT: if (legal_in) state_nxt = S_PLAY;
            S_PLAY:  if (step && last) state_nxt = S_REP;
            S_REP: begin
                if (fail)                  state_nxt = dead ? S_LOSE : S_PLAY;
                else if (in_valid && last) state_nxt = (count == DEPTH_C) ? S_WIN : S_INPUT;
            end
            S_LOSE, S_WIN: if (restart) state_nxt = S_INPUT;
            default: state_nxt = S_INPUT;
        endcase
    end

    // Counters, lives, repeat timer and the win blink phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            index   <= '0;
            lives   <= LIVES_C;
            timer   <= '0;
            win_tog <= 1'b1;
        end else begin
            case (state)
                S_INPUT: begin
                    if (legal_in) begin
                        count <= count + ONE_C;
                        index <= '0;
                        timer <= '0;
                    end
                end
                S_PLAY: begin
                    if (step) begin
                        if (last) begin
                            index <= '0;
                            timer <= '0;
                        end else begin
                            index <= index + ONE_C;
                        end
                    end
                end
                S_REP: begin
                    if (fail) begin
                        lives <= lives_dec;
                        index <= '0;
                        timer <= '0;
                    end else if (in_valid) begin
                        timer <= '0;
                        if (last) begin
                            index   <= '0;
                            win_tog <= 1'b1;
                        end else begin
                            index <= index + ONE_C;
                        end
                    end else if (step && (TIMEOUT > 0)) begin
                        timer <= timer + TW'(1);
                    end
                end
                S_LOSE: begin
                    if (restart) begin
                        count <= '0;
                        index <= '0;
                        lives <= LIVES_C;
                        timer <= '0;
                    end else if (step) begin
                        index <= last ? '0 : index + ONE_C;
                    end
                end
                S_WIN: begin
                    if (restart) begin
                        count <= '0;
                        index <= '0;
                        lives <= LIVES_C;
                        timer <= '0;
                    end else if (step) begin
                        win_tog <= ~win_tog;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pattern memory: written only on an accepted entry, never reset.
    always_ff @(posedge clk) begin
        if ((state == S_INPUT) && legal_in) mem[wr_addr] <= in_pattern;
    end

    // Display and status outputs decoded from the current state.
    always_comb begin
        mode_leds   = 3'b001;
        out_valid   = 1'b0;
        out_pattern = '0;
        win         = 1'b0;
        lose        = 1'b0;
        case (state)
            S_PLAY: begin
                mode_leds   = 3'b010;
                out_valid   = 1'b1;
                out_pattern = rd_dat;
            end
            S_REP: mode_leds = 3'b100;
            S_LOSE: begin
                mode_leds   = 3'b111;
                out_valid   = 1'b1;
                out_pattern = rd_dat;
                lose        = 1'b1;
            end
            S_WIN: begin
                mode_leds   = 3'b101;
                out_valid   = win_tog;
                out_pattern = win_tog ? '1 : '0;
                win         = 1'b1;
            end
            default: ;
        endcase
    end

    assign level      = count;
    assign lives_left = lives;

endmodule
